// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared state encoding and counter sizing for the serial subtractor
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width: ceil(log2(w)), never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational subtract cell with borrow
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - borrow_in, LSB first, one bit per clock
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             fs_diff, fs_bout;

  full_subtractor u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .diff (fs_diff),
    .bout (fs_bout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          br_d    = borrow_in;
          a_sh_d  = a;
          b_sh_d  = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Difference bits shift into the top of the minuend register as it empties.
        a_sh_d = {fs_diff, a_sh_q[WIDTH-1:1]};
        b_sh_d = b_sh_q >> 1;
        br_d   = fs_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          diff_d  = {fs_diff, a_sh_q[WIDTH-1:1]};
          bout_d  = fs_bout;
          ovf_d   = (a_msb_q ^ b_msb_q) & (fs_diff ^ a_msb_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign difference = diff_q;
  assign borrow_out = bout_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH=8
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [W-1:0] difference;
  logic         borrow_out;
  logic         overflow;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vbin;
    exp_t         e;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    logic [W:0] full;
    exp_t       e;
    full   = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    e.diff = full[W-1:0];
    e.bout = full[W];
    e.ovf  = (ma[W-1] != mb[W-1]) && (e.diff[W-1] != ma[W-1]);
    return e;
  endfunction

  // Scoreboard: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, required no pending result");
      end else begin
        mon_e = sb_q.pop_front();
        n_vec++;
        if (difference !== mon_e.diff) begin
          n_bad++;
          $display("FAIL difference: got %h, required %h", difference, mon_e.diff);
        end
        n_vec++;
        if (borrow_out !== mon_e.bout) begin
          n_bad++;
          $display("FAIL borrow_out: got %b, required %b", borrow_out, mon_e.bout);
        end
        n_vec++;
        if (overflow !== mon_e.ovf) begin
          n_bad++;
          $display("FAIL overflow: got %b, required %b", overflow, mon_e.ovf);
        end
      end
    end
  end

  task automatic drive_start(input logic [W-1:0] ta, input logic [W-1:0] tb,
                             input logic tbin, input exp_t e, input bit push);
    start     = 1'b1;
    a         = ta;
    b         = tb;
    borrow_in = tbin;
    if (push) sb_q.push_back(e);
  endtask

  // Called 1 time unit after an edge with start driven; returns edges from capture to done.
  task automatic run_op(input int pulse_at, output int lat, output int bcyc);
    @(posedge clk);
    #1;
    start = 1'b0;
    bcyc  = busy ? 1 : 0;
    lat   = 0;
    a     = W'($urandom);
    b     = W'($urandom);
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcyc++;
      start = (lat == pulse_at);
      a     = W'($urandom);
      b     = W'($urandom);
      borrow_in = 1'($urandom);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, difference, borrow_out, overflow} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bo=%b ov=%b, required all 0",
               busy, done, difference, borrow_out, overflow);
    end
    start = 1'b1; a = 8'h12; b = 8'h34;
    @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_priority: got busy=%b, required 0", busy);
    end
    rst = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_directed;
    vec_t vecs[7];
    int   lat, bc;
    vecs = '{
      '{8'h05, 8'h03, 1'b0, '{8'h02, 1'b0, 1'b0}},
      '{8'h03, 8'h05, 1'b0, '{8'hFE, 1'b1, 1'b0}},
      '{8'h80, 8'h01, 1'b0, '{8'h7F, 1'b0, 1'b1}},
      '{8'h10, 8'h0F, 1'b1, '{8'h00, 1'b0, 1'b0}},
      '{8'h5A, 8'h5A, 1'b0, '{8'h00, 1'b0, 1'b0}},
      '{8'h7F, 8'hFF, 1'b0, '{8'h80, 1'b1, 1'b1}},
      '{8'h00, 8'h00, 1'b1, '{8'hFF, 1'b1, 1'b0}}
    };
    foreach (vecs[i]) begin
      drive_start(vecs[i].va, vecs[i].vb, vecs[i].vbin, vecs[i].e, 1'b1);
      run_op(-1, lat, bc);
      n_vec++;
      if (lat !== 8) begin
        n_bad++;
        $display("FAIL latency[%0d]: got %0d, required 8", i, lat);
      end
      n_vec++;
      if (bc !== 8) begin
        n_bad++;
        $display("FAIL busy_cycles[%0d]: got %0d, required 8", i, bc);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (done !== 1'b0 || difference !== vecs[i].e.diff) begin
        n_bad++;
        $display("FAIL done_pulse_hold[%0d]: got done=%b diff=%h, required done=0 diff=%h",
                 i, done, difference, vecs[i].e.diff);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ta, tb;
    logic         tbin;
    int           lat, bc;
    for (int i = 0; i < 20; i++) begin
      ta   = W'($urandom);
      tb   = W'($urandom);
      tbin = 1'($urandom);
      drive_start(ta, tb, tbin, model(ta, tb, tbin), 1'b1);
      run_op(-1, lat, bc);
      n_vec++;
      if (lat !== 8) begin
        n_bad++;
        $display("FAIL random_latency[%0d]: got %0d, required 8", i, lat);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    drive_start(8'h05, 8'h03, 1'b0, '{8'h02, 1'b0, 1'b0}, 1'b1);
    run_op(3, lat, bc);
    n_vec++;
    if (lat !== 8) begin
      n_bad++;
      $display("FAIL mid_run_start_latency: got %0d, required 8", lat);
    end
    drive_start(8'hFF, 8'hFF, 1'b0, '{8'h00, 1'b0, 1'b0}, 1'b1);
    run_op(-1, lat, bc);
    n_vec++;
    if (lat !== 8) begin
      n_bad++;
      $display("FAIL back_to_back_latency: got %0d, required 8", lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run;
    int lat, bc;
    int seen_done;
    drive_start(8'h05, 8'h03, 1'b0, '{8'h02, 1'b0, 1'b0}, 1'b1);
    run_op(-1, lat, bc);
    @(posedge clk);
    #1;
    drive_start(8'hC3, 8'h15, 1'b0, '{8'h00, 1'b0, 1'b0}, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, difference, borrow_out, overflow} !== '0) begin
      n_bad++;
      $display("FAIL mid_run_reset: got busy=%b done=%b diff=%h bo=%b ov=%b, required all 0",
               busy, done, difference, borrow_out, overflow);
    end
    rst = 1'b0;
    seen_done = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    n_vec++;
    if (seen_done !== 0) begin
      n_bad++;
      $display("FAIL aborted_done: got %0d done cycles, required 0", seen_done);
    end
    drive_start(8'h40, 8'h41, 1'b0, '{8'hFF, 1'b1, 1'b0}, 1'b1);
    run_op(-1, lat, bc);
    n_vec++;
    if (lat !== 8) begin
      n_bad++;
      $display("FAIL post_reset_latency: got %0d, required 8", lat);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (sb_q.size() !== 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending results, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin a subtraction.
REQ-005 SHALL have port a, input, WIDTH, minuend.
REQ-006 SHALL have port b, input, WIDTH, subtrahend.
REQ-007 SHALL have port borrow_in, input, 1, initial borrow for chaining.
REQ-008 SHALL have port busy, output, 1, high while bits are being processed.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port difference, output, WIDTH, result of a - b - borrow_in, modulo 2^WIDTH.
REQ-011 SHALL have port borrow_out, output, 1, final borrow (unsigned a < b + borrow_in).
REQ-012 SHALL have port overflow, output, 1, two's-complement overflow of the signed interpretation.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1, capture a, b and borrow_in at that edge (k) and go to RUN.
REQ-015 SHALL process one bit per cycle, LSB first, in RUN, on edges k+1 .. k+WIDTH.
REQ-016 SHALL compute each bit as d = a_i ^ b_i ^ br.
REQ-017 SHALL compute the next borrow as br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-018 SHALL use a bit counter of ceil(log2(WIDTH)) bits and leave RUN for DONE at edge k+WIDTH, after the last bit.
REQ-019 SHALL update difference, borrow_out and overflow at edge k+WIDTH only.
REQ-020 SHALL hold difference, borrow_out and overflow until the next completion.
REQ-021 SHALL compute overflow as (a_msb != b_msb) & (difference_msb != a_msb), using the captured operands.
REQ-022 SHALL assert done only in DONE, for exactly one cycle.
REQ-023 SHALL assert busy exactly while in RUN.
REQ-024 SHALL give latency from the start edge to done high of WIDTH cycles.
REQ-025 SHALL ignore start while in RUN; captured operands SHALL be unaffected by input changes during RUN.
REQ-026 SHALL, in DONE with start=1, capture new operands and go directly to RUN (back-to-back, no idle cycle); with start=0 it SHALL go to IDLE.
REQ-027 SHALL give a = b with borrow_in=0 the result difference=0, borrow_out=0, overflow=0.

Reset
REQ-028 SHALL, when rst=1 at an edge, force state to IDLE.
REQ-029 SHALL, under reset, clear the bit counter, borrow register and operand shift registers to 0.
REQ-030 SHALL, under reset, drive busy=0, done=0, difference=0, borrow_out=0 and overflow=0.
REQ-031 SHALL let rst take priority over start.
REQ-032 SHALL discard any operation in progress on reset mid-RUN, with no done pulse.

Structure
REQ-033 SHALL place the state enumeration and the WIDTH-derived counter-width function in shared package sub_pkg.
REQ-034 SHALL instantiate one combinational bit cell, full_subtractor (ports a, b, bin, diff, bout), for the per-bit equations.
REQ-035 SHALL hold everything else (FSM, shift registers, counter) in serial_subtractor.

Verification (WIDTH=8)
REQ-036 SHALL verify a=8'h05, b=8'h03, bin=0 -> done 8 cycles after start; difference=8'h02, borrow_out=0, overflow=0.
REQ-037 SHALL verify a=8'h03, b=8'h05, bin=0 -> difference=8'hFE, borrow_out=1, overflow=0.
REQ-038 SHALL verify a=8'h80, b=8'h01, bin=0 -> difference=8'h7F, borrow_out=0, overflow=1.
REQ-039 SHALL verify a=8'h10, b=8'h0F, bin=1 -> difference=8'h00, borrow_out=0; busy high exactly 8 cycles.
REQ-040 SHALL verify start held high in DONE with new a=8'hFF, b=8'hFF -> next result 8'h00 exactly 8 cycles after the first done; a start pulse mid-RUN is ignored.
REQ-041 SHALL verify rst asserted at bit 4 of a run -> all outputs 0 next cycle, no done pulse; a following start completes normally.
